tmr_vote_controller: RTL

- Sequenced, fault-tracking wrapper around the bitwise 3-input majority voter for triple-modular-redundant (TMR) channels a/b/c.
- Samples the three channels on `valid_in` and registers the voted result.
- Tracks consecutive disagreements per channel and retires a channel after MISS_LIMIT misses, then degrades voting gracefully.
- Sits between redundant producer copies and the single downstream consumer.

---
 rtl/tmr_pkg.sv | 13 +
 rtl/majority_voter.sv | 11 +
 rtl/tmr_vote_controller.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/tmr_pkg.sv
// Shared types and widths for the TMR vote controller and its channel FSMs.
package tmr_pkg;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SUSPECT = 2'd1,
        FAULTY  = 2'd2
    } chan_state_t;

    localparam int CNT_W         = 4;
    localparam int MISS_EVENTS_W = 16;

endpackage

// File: rtl/majority_voter.sv
// Single-bit 2-of-3 majority voter.
module majority_voter (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/tmr_vote_controller.sv
// TMR vote controller: registered bitwise vote over channels a/b/c with per-channel
// miss tracking, channel retirement and degraded 2/1/0-healthy voting.
module tmr_vote_controller
    import tmr_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int MISS_LIMIT = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             valid_in,
    input  logic             clear_fault,
    output logic [WIDTH-1:0] y,
    output logic             valid_out,
    output logic [2:0]       fault,
    output logic             disagree,
    output logic             all_failed,
    output logic [15:0]      miss_events
);

    localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(MISS_LIMIT);

    logic [WIDTH-1:0]         chan_word [3];
    logic [WIDTH-1:0]         maj_word;
    logic [WIDTH-1:0]         vote_word;
    logic                     disagree_next;
    logic [2:0]               fault_cur;
    logic [2:0]               fault_next;
    logic [2:0]               healthy;
    logic [2:0]               mismatch;
    logic [1:0]               miss_inc;
    logic [MISS_EVENTS_W:0]   miss_sum;

    logic [WIDTH-1:0]         y_reg;
    logic                     valid_out_reg;
    logic                     disagree_reg;
    logic                     all_failed_reg;
    logic [MISS_EVENTS_W-1:0] miss_events_reg;

    assign chan_word[0] = a;
    assign chan_word[1] = b;
    assign chan_word[2] = c;
    assign healthy      = ~fault_cur;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_vote
            majority_voter u_maj (
                .a (a[gi]),
                .b (b[gi]),
                .c (c[gi]),
                .y (maj_word[gi])
            );
        end
    endgenerate

    // With no healthy channel the vote source is the previous y, so y simply holds.
    always_comb begin
        vote_word     = y_reg;
        disagree_next = 1'b0;
        case (healthy)
            3'b111: vote_word = maj_word;
            3'b011: begin vote_word = a; disagree_next = (a != b); end
            3'b101: begin vote_word = a; disagree_next = (a != c); end
            3'b110: begin vote_word = b; disagree_next = (b != c); end
            3'b001: vote_word = a;
            3'b010: vote_word = b;
            3'b100: vote_word = c;
            default: vote_word = y_reg;
        endcase
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            chan_state_t      state_reg;
            chan_state_t      state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic [CNT_W-1:0] cnt_inc;

            assign cnt_inc        = cnt_reg + CNT_W'(1);
            assign mismatch[gi]   = healthy[gi] && (chan_word[gi] != vote_word);
            assign fault_cur[gi]  = (state_reg == FAULTY);
            assign fault_next[gi] = (state_next == FAULTY);

            // A clear wins over a simultaneous sample: that sample's misses never reach the FSM.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                if (clear_fault) begin
                    state_next = OK;
                    cnt_next   = '0;
                end else if (valid_in) begin
                    case (state_reg)
                        OK: begin
                            if (mismatch[gi]) begin
                                cnt_next   = CNT_W'(1);
                                state_next = (MISS_LIMIT == 1) ? FAULTY : SUSPECT;
                            end
                        end
                        SUSPECT: begin
                            if (!mismatch[gi]) begin
                                state_next = OK;
                                cnt_next   = '0;
                            end else begin
                                cnt_next = cnt_inc;
                                if (cnt_inc == LIMIT_CNT) begin
                                    state_next = FAULTY;
                                end
                            end
                        end
                        default: state_next = state_reg;
                    endcase
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg <= OK;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end
        end
    endgenerate

    assign miss_inc = {1'b0, mismatch[0]} + {1'b0, mismatch[1]} + {1'b0, mismatch[2]};
    assign miss_sum = {1'b0, miss_events_reg} + (MISS_EVENTS_W + 1)'(miss_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg           <= '0;
            valid_out_reg   <= 1'b0;
            disagree_reg    <= 1'b0;
            all_failed_reg  <= 1'b0;
            miss_events_reg <= '0;
        end else begin
            valid_out_reg <= valid_in;
            if (valid_in) begin
                y_reg        <= vote_word;
                disagree_reg <= disagree_next;
                miss_events_reg <= miss_sum[MISS_EVENTS_W] ? '1 : miss_sum[MISS_EVENTS_W-1:0];
            end
            if (clear_fault) begin
                all_failed_reg <= 1'b0;
            end else if (&fault_next) begin
                all_failed_reg <= 1'b1;
            end
        end
    end

    assign y           = y_reg;
    assign valid_out   = valid_out_reg;
    assign fault       = fault_cur;
    assign disagree    = disagree_reg;
    assign all_failed  = all_failed_reg;
    assign miss_events = miss_events_reg;

endmodule
